data_io_fifo: RTL and testbench

//  Next-generation IO-controller download engine. Receives files from the IO

---
 rtl/data_io_fifo.sv | 149 ++++++++++++++
 tb/tb_data_io_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/data_io_fifo.sv
// data_io_fifo: SPI file download engine feeding external RAM writes through a byte+address FIFO
module data_io_fifo #(
  parameter int                ADDR_W     = 25,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] BASE_TAPE  = 'h200000,
  parameter logic [ADDR_W-1:0] BASE_ROM   = 'h100000,
  parameter bit                JMP_PATCH  = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sck,
  input  logic              ss,
  input  logic              sdi,
  output logic              downloading,
  output logic [4:0]        index,
  output logic [ADDR_W-1:0] size,
  output logic              overflow,
  output logic              wr,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] a,
  output logic [7:0]        d
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [2:0]        sck_s;
  logic [1:0]        ss_s, sdi_s;
  logic [6:0]        sr;
  logic [3:0]        bcnt;
  logic [7:0]        cmd, dat, rx, s_hi, d0;
  logic              dat_vld, rise, end_f, patch, is_dat, pop, acc0, acc1, drop;
  logic [4:0]        new_index;
  logic [1:0]        hcnt, n_push;
  logic [ADDR_W-1:0] ptr, a0;
  logic [PW-1:0]     wp, wp1, rp;
  logic [CW-1:0]     cnt, free;
  logic [ADDR_W-1:0] fa [FIFO_DEPTH];
  logic [7:0]        fd [FIFO_DEPTH];

  assign rise   = sck_s[1] & ~sck_s[2];
  assign rx     = {sr, sdi_s[1]};
  assign patch  = JMP_PATCH && index != 5'd0;
  assign is_dat = dat_vld && cmd == 8'h54 && downloading && !end_f;
  assign pop    = wr && wr_ack;
  assign free   = CW'(FIFO_DEPTH) - cnt;
  assign wp1    = wp + 1'b1;

  always_comb begin
    n_push = !is_dat ? 2'd0 : patch && hcnt == 2'd1 ? 2'd2 : 2'd1;
    a0     = !patch || hcnt == 2'd2 ? ptr : ADDR_W'(hcnt);
    d0     = patch && hcnt == 2'd0 ? 8'hC3 : dat;
    acc0   = n_push != 2'd0 && free != '0;
    acc1   = n_push == 2'd2 && free >= CW'(2);
    drop   = (n_push != 2'd0 && !acc0) || (n_push == 2'd2 && !acc1);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sck_s   <= '0;
      ss_s    <= '1;
      sdi_s   <= '0;
      sr      <= '0;
      bcnt    <= '0;
      cmd     <= '0;
      dat     <= '0;
      dat_vld <= 1'b0;
    end else begin
      sck_s   <= {sck_s[1:0], sck};
      ss_s    <= {ss_s[0], ss};
      sdi_s   <= {sdi_s[0], sdi};
      dat_vld <= !ss_s[1] && rise && bcnt == 4'd15;
      if (ss_s[1]) bcnt <= '0;
      else if (rise) begin
        sr   <= rx[6:0];
        bcnt <= bcnt == 4'd15 ? 4'd8 : bcnt + 4'd1;
        if (bcnt == 4'd7) cmd <= rx;
        if (bcnt == 4'd15) dat <= rx;
      end
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      downloading <= 1'b0;
      index       <= '0;
      size        <= '0;
      overflow    <= 1'b0;
      new_index   <= '0;
      end_f       <= 1'b0;
      hcnt        <= '0;
      s_hi        <= '0;
      ptr         <= '0;
    end else begin
      if (dat_vld && cmd == 8'h55) new_index <= dat[4:0];
      if (is_dat) begin
        size <= size + 1'b1;
        hcnt <= hcnt == 2'd2 ? hcnt : hcnt + 2'd1;
        if (patch && hcnt == 2'd0) s_hi <= dat;
        if (patch && hcnt == 2'd1) ptr <= ADDR_W'({s_hi, dat});
        else if (!patch || hcnt == 2'd2) ptr <= ptr + 1'b1;
      end
      if (drop) overflow <= 1'b1;
      if (downloading && end_f && cnt == '0 && !wr) begin
        downloading <= 1'b0;
        end_f       <= 1'b0;
      end
      if (dat_vld && cmd == 8'h53) begin
        if (dat[0]) begin
          downloading <= 1'b1;
          index       <= new_index;
          size        <= '0;
          overflow    <= 1'b0;
          ptr         <= new_index == 5'd0 ? BASE_TAPE : BASE_ROM;
          hcnt        <= '0;
          end_f       <= 1'b0;
        end else if (downloading) end_f <= 1'b1;
      end
    end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      wr  <= 1'b0;
      a   <= '0;
      d   <= '0;
    end else begin
      wp  <= wp + PW'(acc0) + PW'(acc1);
      cnt <= cnt + CW'(acc0) + CW'(acc1) - CW'(pop);
      if (!wr && cnt != '0) begin
        wr <= 1'b1;
        a  <= fa[rp];
        d  <= fd[rp];
      end else if (pop) begin
        wr <= 1'b0;
        rp <= rp + 1'b1;
      end
    end

  always_ff @(posedge clk) begin
    if (acc0) begin
      fa[wp] <= a0;
      fd[wp] <= d0;
    end
    if (acc1) begin
      fa[wp1] <= ADDR_W'(2);
      fd[wp1] <= s_hi;
    end
  end
endmodule

// File: tb/tb_data_io_fifo.sv
// tb_data_io_fifo: directed vector and corner-sequence bench for data_io_fifo
module tb_data_io_fifo;
  logic        clk = 1'b0, reset_n = 1'b0, sck = 1'b0, ss = 1'b1, sdi = 1'b0, wr_ack = 1'b0;
  logic        downloading, overflow, wr;
  logic [4:0]  index;
  logic [24:0] size, a;
  logic [7:0]  d;
  int          tests = 0, fails = 0, stab_err = 0;
  bit          ack_en = 1'b1;
  logic        prev_wr = 1'b0, prev_ack = 1'b0;
  logic [32:0] prev_ad = '0;
  logic [31:0] wa [$];
  logic [7:0]  wd [$];
  typedef struct {
    logic [4:0]  idx;
    int          n;
    logic [7:0]  b [4];
    int          nw;
    logic [31:0] ea [5];
    logic [7:0]  ed [5];
  } vec_t;
  vec_t v [5];

  data_io_fifo dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .ss(ss), .sdi(sdi),
    .downloading(downloading), .index(index), .size(size), .overflow(overflow),
    .wr(wr), .wr_ack(wr_ack), .a(a), .d(d)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prev_wr && !prev_ack && wr && {a, d} != prev_ad) stab_err++;
    if (prev_ack && wr) stab_err++;
    wr_ack = wr && ack_en;
    if (wr_ack) begin
      wa.push_back(32'(a));
      wd.push_back(d);
    end
    prev_wr  = wr;
    prev_ack = wr_ack;
    prev_ad  = {a, d};
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sdi = b[i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic frame_begin(input logic [7:0] c);
    ss = 1'b0;
    #40;
    spi_bits(c, 8);
  endtask

  task automatic frame_end();
    #40 ss = 1'b1;
    #80;
  endtask

  task automatic cmd1(input logic [7:0] c, input logic [7:0] b);
    frame_begin(c);
    spi_bits(b, 8);
    frame_end();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && downloading; i++) @(negedge clk);
    chk("dl_fall", 32'(downloading), 0);
  endtask

  initial begin
    v[0] = '{5'd0, 3, '{8'h11, 8'h22, 8'h33, 8'h00}, 3,
             '{32'h200000, 32'h200001, 32'h200002, 0, 0}, '{8'h11, 8'h22, 8'h33, 0, 0}};
    v[1] = '{5'd2, 4, '{8'hE0, 8'h00, 8'hAA, 8'hBB}, 5,
             '{32'h0, 32'h1, 32'h2, 32'hE000, 32'hE001}, '{8'hC3, 8'h00, 8'hE0, 8'hAA, 8'hBB}};
    v[2] = '{5'd1, 2, '{8'h12, 8'h34, 8'h00, 8'h00}, 3,
             '{32'h0, 32'h1, 32'h2, 0, 0}, '{8'hC3, 8'h34, 8'h12, 0, 0}};
    v[3] = '{5'd31, 3, '{8'h00, 8'h10, 8'h5A, 8'h00}, 4,
             '{32'h0, 32'h1, 32'h2, 32'h0010, 0}, '{8'hC3, 8'h10, 8'h00, 8'h5A, 0}};
    v[4] = '{5'd0, 1, '{8'h7F, 8'h00, 8'h00, 8'h00}, 1,
             '{32'h200000, 0, 0, 0, 0}, '{8'h7F, 0, 0, 0, 0}};
    repeat (3) @(negedge clk);
    chk("rst_dl", 32'(downloading), 0);
    chk("rst_index", 32'(index), 0);
    chk("rst_size", 32'(size), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_a", 32'(a), 0);
    chk("rst_d", 32'(d), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    cmd1(8'h54, 8'h99);
    repeat (20) @(negedge clk);
    chk("idle_dat_nw", wa.size(), 0);
    chk("idle_dat_size", 32'(size), 0);
    chk("idle_dat_dl", 32'(downloading), 0);
    for (int k = 0; k < 5; k++) begin
      wa.delete();
      wd.delete();
      cmd1(8'h55, {3'b000, v[k].idx});
      cmd1(8'h53, 8'h01);
      chk($sformatf("v%0d_dl_start", k), 32'(downloading), 1);
      chk($sformatf("v%0d_index", k), 32'(index), 32'(v[k].idx));
      frame_begin(8'h54);
      for (int j = 0; j < v[k].n; j++) spi_bits(v[k].b[j], 8);
      frame_end();
      cmd1(8'h53, 8'h00);
      wait_idle();
      chk($sformatf("v%0d_size", k), 32'(size), 32'(v[k].n));
      chk($sformatf("v%0d_ovf", k), 32'(overflow), 0);
      chk($sformatf("v%0d_nw", k), wa.size(), 32'(v[k].nw));
      for (int j = 0; j < v[k].nw && j < wa.size(); j++) begin
        chk($sformatf("v%0d_a%0d", k, j), wa[j], v[k].ea[j]);
        chk($sformatf("v%0d_d%0d", k, j), 32'(wd[j]), 32'(v[k].ed[j]));
      end
    end
    wa.delete();
    wd.delete();
    ack_en = 1'b0;
    cmd1(8'h55, 8'h00);
    cmd1(8'h53, 8'h01);
    frame_begin(8'h54);
    for (int j = 0; j < 8; j++) spi_bits(8'h80 + 8'(j), 8);
    frame_end();
    repeat (200) @(negedge clk);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_size", 32'(size), 8);
    chk("ovf_wr_held", 32'(wr), 1);
    chk("ovf_a_held", 32'(a), 32'h200000);
    chk("ovf_d_held", 32'(d), 32'h80);
    chk("ovf_nw_held", wa.size(), 0);
    ack_en = 1'b1;
    cmd1(8'h53, 8'h00);
    wait_idle();
    chk("ovf_nw", wa.size(), 4);
    for (int j = 0; j < 4 && j < wa.size(); j++) begin
      chk($sformatf("ovf_a%0d", j), wa[j], 32'h200000 + 32'(j));
      chk($sformatf("ovf_d%0d", j), 32'(wd[j]), 32'h80 + 32'(j));
    end
    wa.delete();
    wd.delete();
    cmd1(8'h55, 8'h00);
    cmd1(8'h53, 8'h01);
    frame_begin(8'h54);
    spi_bits(8'h44, 8);
    spi_bits(8'hF0, 5);
    frame_end();
    chk("ss_size_mid", 32'(size), 1);
    frame_begin(8'h54);
    spi_bits(8'h66, 8);
    frame_end();
    cmd1(8'h53, 8'h00);
    wait_idle();
    chk("ss_size", 32'(size), 2);
    chk("ss_nw", wa.size(), 2);
    for (int j = 0; j < 2 && j < wa.size(); j++) begin
      chk($sformatf("ss_a%0d", j), wa[j], 32'h200000 + 32'(j));
      chk($sformatf("ss_d%0d", j), 32'(wd[j]), j == 0 ? 32'h44 : 32'h66);
    end
    wa.delete();
    wd.delete();
    ack_en = 1'b0;
    cmd1(8'h55, 8'h00);
    cmd1(8'h53, 8'h01);
    frame_begin(8'h54);
    spi_bits(8'hA1, 8);
    spi_bits(8'hA2, 8);
    spi_bits(8'hA3, 8);
    frame_end();
    repeat (5) @(negedge clk);
    chk("rst_pre_wr", 32'(wr), 1);
    chk("rst_pre_dl", 32'(downloading), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_dl", 32'(downloading), 0);
    chk("arst_size", 32'(size), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_wr", 32'(wr), 0);
    chk("arst_a", 32'(a), 0);
    chk("arst_d", 32'(d), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ack_en  = 1'b1;
    repeat (100) @(negedge clk);
    chk("arst_post_nw", wa.size(), 0);
    chk("arst_post_dl", 32'(downloading), 0);
    chk("arst_post_wr", 32'(wr), 0);
    chk("stable_ad", 32'(stab_err), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
